// File: rtl/uart_rx_cmd_decoder.sv
`timescale 1ns/1ps
// UART command-frame decoder: parses HDR,CMD,ADDR,DATA,CHK byte streams into a
// held command with valid/ready handshake, checksum/timeout/overrun error pulses.
module uart_rx_cmd_decoder #(
  parameter int unsigned TIMEOUT_CLKS = 1740,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Cmd_Valid,
  input  logic       i_Cmd_Ready,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Addr,
  output logic [7:0] o_Data,
  output logic       o_Err_Chksum,
  output logic       o_Err_Timeout,
  output logic       o_Overrun,
  output logic [7:0] o_Frame_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_CMD  = 3'd1,
    S_GET_ADDR = 3'd2,
    S_GET_DATA = 3'd3,
    S_GET_CHK  = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [7:0]  data_sh_q, data_sh_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_chk_q, err_chk_d;
  logic        err_tmo_q, err_tmo_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  chk_s;
  logic        in_frame_s;

  assign chk_s      = cmd_sh_q ^ addr_sh_q ^ data_sh_q;
  assign in_frame_s = (state_q == S_GET_CMD) || (state_q == S_GET_ADDR) ||
                      (state_q == S_GET_DATA) || (state_q == S_GET_CHK);

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      cmd_sh_q  <= 8'h00;
      addr_sh_q <= 8'h00;
      data_sh_q <= 8'h00;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_chk_q <= 1'b0;
      err_tmo_q <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= 8'h00;
      tmo_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      cmd_sh_q  <= cmd_sh_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_chk_q <= err_chk_d;
      err_tmo_q <= err_tmo_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_sh_d  = cmd_sh_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    err_chk_d = 1'b0;
    err_tmo_d = 1'b0;
    ovr_d     = 1'b0;
    cnt_d     = cnt_q;
    tmo_d     = 16'd0;
    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == HDR_BYTE)) state_d = S_GET_CMD;
        else                                    state_d = S_IDLE;
      end
      S_GET_CMD: begin
        if (i_Rx_DV) begin
          cmd_sh_d = i_Rx_Byte;
          state_d  = S_GET_ADDR;
        end else begin
          state_d = S_GET_CMD;
        end
      end
      S_GET_ADDR: begin
        if (i_Rx_DV) begin
          addr_sh_d = i_Rx_Byte;
          state_d   = S_GET_DATA;
        end else begin
          state_d = S_GET_ADDR;
        end
      end
      S_GET_DATA: begin
        if (i_Rx_DV) begin
          data_sh_d = i_Rx_Byte;
          state_d   = S_GET_CHK;
        end else begin
          state_d = S_GET_DATA;
        end
      end
      S_GET_CHK: begin
        if (i_Rx_DV && (i_Rx_Byte == chk_s)) begin
          cmd_d   = cmd_sh_q;
          addr_d  = addr_sh_q;
          data_d  = data_sh_q;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else if (i_Rx_DV) begin
          err_chk_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_GET_CHK;
        end
      end
      S_HOLD: begin
        // Any byte arriving here is dropped, even on the acceptance cycle.
        ovr_d = i_Rx_DV;
        if (i_Cmd_Ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // A strobe always wins over an expiring inter-byte timer.
    if (in_frame_s && !i_Rx_DV) begin
      if (tmo_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end else begin
      tmo_d = 16'd0;
    end
  end

  assign o_Cmd_Valid   = valid_q;
  assign o_Cmd         = cmd_q;
  assign o_Addr        = addr_q;
  assign o_Data        = data_q;
  assign o_Err_Chksum  = err_chk_q;
  assign o_Err_Timeout = err_tmo_q;
  assign o_Overrun     = ovr_q;
  assign o_Frame_Cnt   = cnt_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
`timescale 1ns/1ps
// Directed self-checking bench for uart_rx_cmd_decoder.
module tb_uart_rx_cmd_decoder;

  localparam int T = 1740;

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd, addr, data;
  logic       err_chk, err_tmo, ovr;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int n_chk = 0;
  int n_tmo = 0;
  int n_ovr = 0;
  int n_multi = 0;

  uart_rx_cmd_decoder #(.TIMEOUT_CLKS(T), .HDR_BYTE(8'hA5)) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .o_Cmd_Valid  (cmd_valid),
    .i_Cmd_Ready  (cmd_ready),
    .o_Cmd        (cmd),
    .o_Addr       (addr),
    .o_Data       (data),
    .o_Err_Chksum (err_chk),
    .o_Err_Timeout(err_tmo),
    .o_Overrun    (ovr),
    .o_Frame_Cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally error-pulse cycles and any cycle with more than one error high.
  always @(negedge clk) begin
    if (err_chk) n_chk++;
    if (err_tmo) n_tmo++;
    if (ovr)     n_ovr++;
    if ((32'(err_chk) + 32'(err_tmo) + 32'(ovr)) > 32'd1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(d);
    send_byte(k);
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [7:0] c,
                            input logic [7:0] a, input logic [7:0] d, input logic [7:0] n);
    check({tag, "_valid"}, 32'(cmd_valid), 32'(v));
    check({tag, "_cmd"},   32'(cmd),       32'(c));
    check({tag, "_addr"},  32'(addr),      32'(a));
    check({tag, "_data"},  32'(data),      32'(d));
    check({tag, "_cnt"},   32'(frame_cnt), 32'(n));
  endtask

  initial begin
    int stable_bad;
    logic [7:0] c, a, d;
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_outs("reset", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset_errs", {29'd0, err_chk, err_tmo, ovr}, 32'd0);

    // Good frame, ready already high: one-cycle valid.
    cmd_ready = 1'b1;
    send_frame(8'h01, 8'h10, 8'h55, 8'h44);
    check_outs("good1", 1'b1, 8'h01, 8'h10, 8'h55, 8'h00);
    tick();
    check_outs("good1_acc", 1'b0, 8'h01, 8'h10, 8'h55, 8'h01);

    // Bad checksum, then recovery.
    send_frame(8'h01, 8'h10, 8'h55, 8'h45);
    check("chk_pulse", 32'(err_chk), 32'd1);
    check_outs("chk_bad", 1'b0, 8'h01, 8'h10, 8'h55, 8'h01);
    tick();
    check("chk_pulse_end", 32'(err_chk), 32'd0);
    send_frame(8'h03, 8'h30, 8'h0F, 8'h3C);
    check_outs("good2", 1'b1, 8'h03, 8'h30, 8'h0F, 8'h01);
    tick();
    check("good2_cnt", 32'(frame_cnt), 32'd2);

    // Inter-byte timeout after A5,01.
    send_byte(8'hA5); send_byte(8'h01);
    repeat (T - 1) tick();
    check("tmo_early", 32'(err_tmo), 32'd0);
    tick();
    check("tmo_pulse", 32'(err_tmo), 32'd1);
    tick();
    check("tmo_pulse_end", 32'(err_tmo), 32'd0);
    send_frame(8'h10, 8'h20, 8'h30, 8'h00);
    check_outs("good3", 1'b1, 8'h10, 8'h20, 8'h30, 8'h02);
    tick();

    // Byte arriving on the would-be timeout cycle wins.
    send_byte(8'hA5); send_byte(8'h01);
    repeat (T - 1) tick();
    send_byte(8'h10);
    check("tmo_bytewins", 32'(err_tmo), 32'd0);
    send_byte(8'h55); send_byte(8'h44);
    check_outs("good4", 1'b1, 8'h01, 8'h10, 8'h55, 8'h03);
    tick();
    check("good4_cnt", 32'(frame_cnt), 32'd4);

    // Held command with an overrun byte while not ready.
    cmd_ready = 1'b0;
    send_frame(8'h07, 8'h08, 8'h09, 8'h06);
    stable_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        send_byte(8'h33);
        check("ovr_pulse", 32'(ovr), 32'd1);
      end else begin
        tick();
      end
      if (cmd_valid !== 1'b1 || cmd !== 8'h07 || addr !== 8'h08 || data !== 8'h09 ||
          frame_cnt !== 8'h04) stable_bad++;
    end
    check("hold_stable", 32'(stable_bad), 32'd0);
    cmd_ready = 1'b1;
    tick();
    check_outs("hold_acc", 1'b0, 8'h07, 8'h08, 8'h09, 8'h05);

    // Strobe on the acceptance cycle is dropped, not taken as a header.
    cmd_ready = 1'b0;
    send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
    tick(); tick();
    cmd_ready = 1'b1;
    send_byte(8'hA5);
    check("acc_ovr", 32'(ovr), 32'd1);
    check_outs("acc_drop", 1'b0, 8'h0A, 8'h0B, 8'h0C, 8'h06);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h55); send_byte(8'h44);
    check_outs("acc_noparse", 1'b0, 8'h0A, 8'h0B, 8'h0C, 8'h06);

    // Reset mid-frame discards the partial frame.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_outs("midrst", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    send_byte(8'h55); send_byte(8'h44);
    check_outs("midrst_after", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

    // 256 good frames wrap the frame counter.
    for (int i = 0; i < 256; i++) begin
      c = 8'(i); a = ~8'(i); d = 8'(i + 3);
      send_frame(c, a, d, c ^ a ^ d);
      tick();
      if (i == 254) check("cnt_ff", 32'(frame_cnt), 32'hFF);
    end
    check_outs("wrap", 1'b0, 8'hFF, 8'h00, 8'h02, 8'h00);

    // Stray bytes in IDLE are ignored.
    send_byte(8'h00); send_byte(8'hFF);
    tick();
    check_outs("stray", 1'b0, 8'hFF, 8'h00, 8'h02, 8'h00);

    check("n_chksum_pulses", 32'(n_chk), 32'd1);
    check("n_timeout_pulses", 32'(n_tmo), 32'd1);
    check("n_overrun_pulses", 32'(n_ovr), 32'd2);
    check("err_exclusive", 32'(n_multi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_decoder.md
UART_RX_CMD_DECODER -- requirements
Module: uart_rx_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 1740, meaning the maximum number of clocks between consecutive frame bytes before the frame is abandoned.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, meaning the frame header value.
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_Reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port i_Rx_DV, input, 1 bit: one-cycle strobe marking a received byte from the UART receiver.
REQ-006 SHALL have port i_Rx_Byte, input, 8 bits: received byte, valid only when i_Rx_DV=1.
REQ-007 SHALL have port o_Cmd_Valid, output, 1 bit: a decoded command is available.
REQ-008 SHALL have port i_Cmd_Ready, input, 1 bit: the consumer accepts the command.
REQ-009 SHALL have port o_Cmd, output, 8 bits: command opcode.
REQ-010 SHALL have port o_Addr, output, 8 bits: register address.
REQ-011 SHALL have port o_Data, output, 8 bits: payload byte.
REQ-012 SHALL have port o_Err_Chksum, output, 1 bit: one-cycle pulse on checksum mismatch.
REQ-013 SHALL have port o_Err_Timeout, output, 1 bit: one-cycle pulse on an inter-byte timeout.
REQ-014 SHALL have port o_Overrun, output, 1 bit: one-cycle pulse when a byte is dropped while a command is held.
REQ-015 SHALL have port o_Frame_Cnt, output, 8 bits: count of accepted commands, wrapping.

Function
REQ-016 SHALL accept the frame format HDR, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
REQ-017 SHALL implement states IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, HOLD.
REQ-018 IDLE: on i_Rx_DV with i_Rx_Byte==HDR_BYTE SHALL go to GET_CMD; SHALL silently ignore any other byte.
REQ-019 GET_CMD, GET_ADDR, GET_DATA: each i_Rx_DV SHALL latch the byte into the matching shadow register and advance one state.
REQ-020 GET_CHK: on i_Rx_DV with byte==XOR of the shadows SHALL copy the shadows to o_Cmd/o_Addr/o_Data, set o_Cmd_Valid=1 on the next cycle, and enter HOLD.
REQ-021 GET_CHK: on i_Rx_DV with a mismatching byte SHALL pulse o_Err_Chksum for one cycle, return to IDLE, and leave the outputs unchanged.
REQ-022 Latency SHALL be exactly 1 clock from the CHK-byte strobe to o_Cmd_Valid=1.
REQ-023 HOLD: o_Cmd_Valid, o_Cmd, o_Addr, o_Data SHALL stay stable until a cycle with i_Cmd_Ready=1.
REQ-024 On that cycle SHALL clear o_Cmd_Valid next cycle, increment o_Frame_Cnt (modulo 256, 8'hFF->8'h00), and return to IDLE.
REQ-025 If i_Cmd_Ready is already 1 when o_Cmd_Valid rises, the command SHALL be accepted in that same cycle, giving 1-cycle valid.
REQ-026 HOLD: any i_Rx_DV SHALL drop the byte and pulse o_Overrun; this includes a strobe coinciding with the acceptance cycle, and such a byte SHALL NOT be parsed as a header.
REQ-027 16-bit timeout counter: SHALL be 0 in IDLE and HOLD, SHALL clear on every accepted i_Rx_DV, and SHALL increment otherwise in GET_* states.
REQ-028 When the counter reaches TIMEOUT_CLKS-1 without a strobe, SHALL pulse o_Err_Timeout and return to IDLE.
REQ-029 If i_Rx_DV coincides with the timeout cycle, the byte SHALL win: it is processed and no timeout occurs.
REQ-030 Error pulses SHALL be mutually exclusive per cycle and SHALL be 0 in all other cycles.
REQ-031 A header byte received mid-frame SHALL be treated as ordinary data, with no resynchronisation.

Reset
REQ-032 When i_Reset_n=0 at a clock edge, SHALL enter IDLE and set o_Cmd_Valid=0, o_Cmd=o_Addr=o_Data=8'h00, all error pulses=0, o_Frame_Cnt=8'h00, counter=0, shadows=0.
REQ-033 Reset SHALL override all other inputs in that cycle, including mid-frame and during HOLD; a partial frame SHALL be discarded.

Verification
REQ-034 Frame A5,01,10,55,44 with i_Cmd_Ready=1 -> o_Cmd_Valid high 1 cycle after the CHK strobe, o_Cmd=01, o_Addr=10, o_Data=55, o_Frame_Cnt=1.
REQ-035 Frame A5,01,10,55,45 -> o_Err_Chksum pulses once, no o_Cmd_Valid, and a following good frame decodes correctly.
REQ-036 A5,01 then no strobe for TIMEOUT_CLKS clocks -> o_Err_Timeout pulses once, state IDLE, and a following good frame decodes.
REQ-037 Good frame with i_Cmd_Ready=0 for 50 cycles while a byte 33 arrives -> o_Overrun pulses once, outputs stable, and the command is accepted when ready rises.
REQ-038 i_Reset_n=0 asserted after A5,01,10 -> all outputs at reset values; the completion bytes 55,44 then produce no command.
REQ-039 256 good frames -> o_Frame_Cnt wraps to 8'h00; stray bytes 00,FF in IDLE -> ignored, with no error pulse.
